// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, state encoding and op-classification helpers for the EX-stage mul/div unit.
// The optional multiply-accumulate path is selected by EX_MULDIV_ACCUM_EN (see ex_muldiv).
package ex_muldiv_pkg;

    localparam int unsigned AluOpW  = 8;
    localparam int unsigned RegBusW = 32;

    typedef logic [AluOpW-1:0]  aluop_t;
    typedef logic [RegBusW-1:0] reg_t;

    localparam logic   RstEnable = 1'b0;
    localparam reg_t   ZeroWord  = '0;

    localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
    localparam aluop_t EXE_MTHI_OP  = 8'b0001_0001;
    localparam aluop_t EXE_MTLO_OP  = 8'b0001_0011;
    localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
    localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
    localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
    localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;
    localparam aluop_t EXE_MADD_OP  = 8'b1010_0110;
    localparam aluop_t EXE_MADDU_OP = 8'b1010_1000;
    localparam aluop_t EXE_MSUB_OP  = 8'b1010_1010;
    localparam aluop_t EXE_MSUBU_OP = 8'b1010_1011;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul  = 3'd1,
        StAcc  = 3'd2,
        StDiv  = 3'd3,
        StDone = 3'd4
    } state_e;

    function automatic logic is_signed_op(input aluop_t op);
        return (op == EXE_MULT_OP) || (op == EXE_MADD_OP) ||
               (op == EXE_MSUB_OP) || (op == EXE_DIV_OP);
    endfunction

    function automatic logic is_acc_op(input aluop_t op);
        return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
               (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

    function automatic logic is_sub_op(input aluop_t op);
        return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

    function automatic logic is_div_op(input aluop_t op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle for ex_muldiv: decoded op and operands in, HI/LO and stall out.
interface ex_muldiv_if #(
    parameter int unsigned DATA_W = 32
);
    import ex_muldiv_pkg::*;

    aluop_t            aluop;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic              annul;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              stallreq;
    logic              busy;

    modport master (
        output aluop, reg1, reg2, annul,
        input  hi, lo, stallreq, busy
    );

    modport slave (
        input  aluop, reg1, reg2, annul,
        output hi, lo, stallreq, busy
    );

endinterface

// File: rtl/ex_muldiv_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, W cycles after start.
// Operands are magnitudes; sign handling belongs to the caller.
module ex_muldiv_div_core
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         last
);

    localparam int unsigned CntW = $clog2(W);

    logic            busy_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    dvs_q;
    logic [W:0]      shifted;
    logic [W:0]      diff;

    // Partial remainder can momentarily need W+1 bits before the trial subtract.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(W - 1)) begin
                busy_q <= 1'b0;
            end
            if (!diff[W]) begin
                rem_q <= diff[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = busy_q && (cnt_q == CntW'(W - 1));

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO; stalls ID while an op is in flight.
// Define EX_MULDIV_ACCUM_EN to enable MADD/MADDU/MSUB/MSUBU (ACC state + accumulate adder).
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);

    localparam int unsigned ProdW = 2 * DATA_W;

    state_e              state_q, state_d;
    aluop_t              op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ProdW-1:0]    res_q, res_d;
    logic                wr_q, wr_d;
    logic                quo_neg_q, quo_neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                stallreq;
    logic                mul_op;
    logic                div_start;
    logic                div_abort;
    logic                div_last;
    logic [DATA_W-1:0]   div_quo;
    logic [DATA_W-1:0]   div_rem;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic                in_signed;
    logic [ProdW-1:0]    a_ext;
    logic [ProdW-1:0]    b_ext;
    logic [ProdW-1:0]    product;

`ifdef EX_MULDIV_ACCUM_EN
    assign mul_op = (bus.aluop == EXE_MULT_OP) || (bus.aluop == EXE_MULTU_OP) ||
                    is_acc_op(bus.aluop);
`else
    assign mul_op = (bus.aluop == EXE_MULT_OP) || (bus.aluop == EXE_MULTU_OP);
`endif

    assign in_signed = is_signed_op(bus.aluop);
    assign abs_a     = (in_signed && bus.reg1[DATA_W-1]) ? -bus.reg1 : bus.reg1;
    assign abs_b     = (in_signed && bus.reg2[DATA_W-1]) ? -bus.reg2 : bus.reg2;

    // Sign/zero extension to full width makes the truncated product correct for both signednesses.
    assign a_ext   = is_signed_op(op_q) ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    assign b_ext   = is_signed_op(op_q) ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    assign product = a_ext * b_ext;

    ex_muldiv_div_core #(
        .W (DATA_W)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        wr_d      = wr_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stallreq  = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;

        if (bus.annul) begin
            state_d   = StIdle;
            div_abort = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.aluop == EXE_MTHI_OP) begin
                        hi_d = bus.reg1;
                    end else if (bus.aluop == EXE_MTLO_OP) begin
                        lo_d = bus.reg1;
                    end else if (mul_op) begin
                        stallreq = 1'b1;
                        op_d     = bus.aluop;
                        a_d      = bus.reg1;
                        b_d      = bus.reg2;
                        wr_d     = 1'b1;
                        state_d  = StMul;
                    end else if (is_div_op(bus.aluop)) begin
                        stallreq  = 1'b1;
                        op_d      = bus.aluop;
                        quo_neg_d = in_signed && (bus.reg1[DATA_W-1] ^ bus.reg2[DATA_W-1]);
                        rem_neg_d = in_signed && bus.reg1[DATA_W-1];
                        // Divide-by-zero skips the iteration and leaves HI/LO untouched.
                        wr_d      = (bus.reg2 != '0);
                        div_start = (bus.reg2 != '0);
                        state_d   = (bus.reg2 != '0) ? StDiv : StDone;
                    end
                end
                StMul: begin
                    stallreq = 1'b1;
                    res_d    = product;
`ifdef EX_MULDIV_ACCUM_EN
                    state_d  = is_acc_op(op_q) ? StAcc : StDone;
`else
                    state_d  = StDone;
`endif
                end
                StAcc: begin
`ifdef EX_MULDIV_ACCUM_EN
                    stallreq = 1'b1;
                    res_d    = is_sub_op(op_q) ? ({hi_q, lo_q} - res_q) : ({hi_q, lo_q} + res_q);
                    state_d  = StDone;
`else
                    state_d  = StIdle;
`endif
                end
                StDiv: begin
                    stallreq = 1'b1;
                    if (div_last) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    if (wr_q) begin
                        if (is_div_op(op_q)) begin
                            lo_d = quo_neg_q ? -div_quo : div_quo;
                            hi_d = rem_neg_q ? -div_rem : div_rem;
                        end else begin
                            {hi_d, lo_d} = res_q;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q   <= StIdle;
            op_q      <= EXE_NOP_OP;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            wr_q      <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            wr_q      <= wr_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.stallreq = stallreq;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: HI/LO results, stall lengths, annul and reset.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   stalls;

    ex_muldiv_if #(.DATA_W(32)) bus ();

    ex_muldiv #(
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction, hold it while stalled, then let it advance past the next edge.
    task automatic issue(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                         output int n_stall);
        n_stall = 0;
        bus.aluop = op;
        bus.reg1  = a;
        bus.reg2  = b;
        #1;
        while (bus.stallreq && n_stall < 100) begin
            n_stall++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #1;
        bus.aluop = EXE_NOP_OP;
        bus.reg1  = '0;
        bus.reg2  = '0;
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        bus.aluop = EXE_NOP_OP;
        bus.reg1  = '0;
        bus.reg2  = '0;
        bus.annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_stall", 32'(bus.stallreq), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(EXE_MULT_OP, 32'hFFFF_FFFE, 32'h0000_0003, stalls);
        check("mult_stall", 32'(stalls), 32'd2);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);

        issue(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'h0000_0003, stalls);
        check("multu_stall", 32'(stalls), 32'd2);
        check("multu_hi", bus.hi, 32'h0000_0002);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);

        issue(EXE_MTHI_OP, 32'd0, 32'd0, stalls);
        check("mthi_stall", 32'(stalls), 32'd0);
        issue(EXE_MTLO_OP, 32'd10, 32'd0, stalls);
        check("mtlo_stall", 32'(stalls), 32'd0);
        check("mthi_hi", bus.hi, 32'h0);
        check("mtlo_lo", bus.lo, 32'd10);

`ifdef EX_MULDIV_ACCUM_EN
        issue(EXE_MADD_OP, 32'd3, 32'd4, stalls);
        check("madd_stall", 32'(stalls), 32'd3);
        check("madd_hi", bus.hi, 32'h0);
        check("madd_lo", bus.lo, 32'd22);
        issue(EXE_MSUB_OP, 32'd5, 32'd5, stalls);
        check("msub_stall", 32'(stalls), 32'd3);
        check("msub_hi", bus.hi, 32'hFFFF_FFFF);
        check("msub_lo", bus.lo, 32'hFFFF_FFFD);
`else
        issue(EXE_MADD_OP, 32'd3, 32'd4, stalls);
        check("madd_off_stall", 32'(stalls), 32'd0);
        check("madd_off_hi", bus.hi, 32'h0);
        check("madd_off_lo", bus.lo, 32'd10);
        issue(EXE_MSUBU_OP, 32'd5, 32'd5, stalls);
        check("msubu_off_stall", 32'(stalls), 32'd0);
        check("msubu_off_lo", bus.lo, 32'd10);
`endif

        issue(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, stalls);
        check("div_stall", 32'(stalls), 32'd33);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(EXE_DIVU_OP, 32'd100, 32'd7, stalls);
        check("divu_stall", 32'(stalls), 32'd33);
        check("divu_lo", bus.lo, 32'd14);
        check("divu_hi", bus.hi, 32'd2);

        issue(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, stalls);
        check("div_negdvs_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_negdvs_hi", bus.hi, 32'd1);

        issue(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, stalls);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        check("div_ovf_hi", bus.hi, 32'h0);

        issue(EXE_MTHI_OP, 32'h11, 32'd0, stalls);
        issue(EXE_MTLO_OP, 32'h22, 32'd0, stalls);
        issue(EXE_DIV_OP, 32'd5, 32'd0, stalls);
        check("div0_stall", 32'(stalls), 32'd1);
        check("div0_hi", bus.hi, 32'h11);
        check("div0_lo", bus.lo, 32'h22);

        // Annul at iteration 10 of a divide.
        bus.aluop = EXE_DIV_OP;
        bus.reg1  = 32'd100;
        bus.reg2  = 32'd7;
        #1;
        check("annul_pre_stall", 32'(bus.stallreq), 32'h1);
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        check("annul_mid_busy", 32'(bus.busy), 32'h1);
        bus.annul = 1'b1;
        #1;
        check("annul_stall", 32'(bus.stallreq), 32'h0);
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        bus.aluop = EXE_NOP_OP;
        bus.reg1  = '0;
        bus.reg2  = '0;
        #1;
        check("annul_busy", 32'(bus.busy), 32'h0);
        check("annul_hi", bus.hi, 32'h11);
        check("annul_lo", bus.lo, 32'h22);

        issue(EXE_DIVU_OP, 32'd9, 32'd2, stalls);
        check("post_annul_stall", 32'(stalls), 32'd33);
        check("post_annul_lo", bus.lo, 32'd4);
        check("post_annul_hi", bus.hi, 32'd1);

        // Reset in the middle of a divide.
        bus.aluop = EXE_DIV_OP;
        bus.reg1  = 32'd1000;
        bus.reg2  = 32'd3;
        repeat (6) @(posedge clk);
        #1;
        bus.aluop = EXE_NOP_OP;
        rst = 1'b0;
        #1;
        check("rstmid_hi", bus.hi, 32'h0);
        check("rstmid_lo", bus.lo, 32'h0);
        check("rstmid_busy", 32'(bus.busy), 32'h0);
        check("rstmid_stall", 32'(bus.stallreq), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(EXE_MULTU_OP, 32'd6, 32'd7, stalls);
        check("post_rst_lo", bus.lo, 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage, directly consuming the decoded `aluop`/`reg1`/`reg2` produced by ID (via the ID/EX register). Owns the architectural HI/LO registers, executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU/MTHI/MTLO, and raises `stallreq_o` to freeze the upstream pipeline while an operation is in flight.

## Interface
- `DATA_W`, 32, operand and HI/LO width; only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `aluop_i`  in  8 (`AluOpBus`)  decoded op from ID/EX; non-muldiv codes are ignored.
- `reg1_i`  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `reg2_i`  in  32  rt operand (divisor / multiplier).
- `annul_i`  in  1  flush; aborts any operation, no HI/LO write.
- `hi_o`  out  32  committed HI.
- `lo_o`  out  32  committed LO.
- `stallreq_o`  out  1  pipeline stall request (combinational from state and `aluop_i`).
- `busy_o`  out  1  state != IDLE (registered).

## Operation
- States: IDLE, MUL, ACC, DIV, DONE.
- IDLE, muldiv op on `aluop_i`, `annul_i`=0: latch operands, `stallreq_o`=1 this cycle.
  - MULT/MULTU -> MUL; MADD*/MSUB* -> MUL; DIV/DIVU with `reg2_i`!=0 -> DIV; divisor 0 -> DONE with HI/LO write suppressed.
  - MTHI/MTLO: write HI/LO at this edge, no stall, stay IDLE.
- MUL: 64-bit product registered (signed for MULT/MADD/MSUB, unsigned otherwise). -> DONE for MULT/MULTU, -> ACC otherwise. `stallreq_o`=1.
- ACC: result = {HI,LO} + product (MADD*) or {HI,LO} − product (MSUB*), 64-bit modulo. -> DONE. `stallreq_o`=1.
- DIV: radix-2 restoring on absolute values, 5-bit counter 0..31, one quotient bit per cycle; -> DONE after count 31. `stallreq_o`=1.
- DONE: `stallreq_o`=0; sign fixup (signed DIV: quotient negated if operand signs differ, remainder takes dividend sign); LO=quotient, HI=remainder (MUL: HI=product[63:32], LO=product[31:0]) written at the edge leaving DONE; -> IDLE unconditionally. The instruction on `aluop_i` advances on the same edge, so it is never re-accepted.
- `annul_i`=1 in any state: -> IDLE next edge, no HI/LO write, `stallreq_o`=0 combinationally.
- Signed −2^31 / −1: LO=0x80000000, HI=0 (modulo result, no trap).

## Timing
- Reset: HI=LO=0, state IDLE, counter 0, `stallreq_o`=0, `busy_o`=0; reset mid-operation discards it.
- Stall cycles (ID frozen): MULT/MULTU 2, MADD*/MSUB* 3, DIV/DIVU 33, divide-by-zero 1, MTHI/MTLO 0.
- HI/LO visible on `hi_o`/`lo_o` the cycle after DONE; an MFHI/MFLO immediately following reaches EX in that cycle and reads the new value without forwarding.
- MTHI followed by MTLO back-to-back: both commit, one per cycle.

## Configuration
- `EX_MULDIV_ACCUM_EN`: defined -> MADD/MADDU/MSUB/MSUBU execute as above with ACC state. Undefined -> ACC state and accumulate adder removed; those opcodes are ignored in IDLE (no stall, HI/LO unchanged).

## Structure
- Shared `define.v`: `AluOpBus`, `EXE_MULT_OP` … `EXE_MSUBU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP`, `RegBus`, `ZeroWord`, `RstEnable` (1'b0), state encodings.
- Sub-module `div_core`: iterative 32-cycle unsigned restoring divider (start, abs operands in, quotient/remainder out, done); sign handling stays in `ex_muldiv`.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> `stallreq_o` high 2 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- MTHI 0, MTLO 10, then MADD 3 × 4 -> 3 stall cycles, LO=22, HI=0; MSUB 5 × 5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV −7 / 2 -> 33 stall cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); DIVU 100/7 -> LO=14, HI=2.
- DIV by 0 with HI=0x11, LO=0x22 -> 1 stall cycle, HI/LO unchanged.
- `annul_i` pulsed at DIV iteration 10 -> stall drops same cycle, HI/LO unchanged, next op accepted normally; `rst` low mid-DIV -> HI=LO=0, IDLE.
- Without `EX_MULDIV_ACCUM_EN`: MADD issued -> no stall, HI/LO unchanged.
